dyn_branch_predictor: RTL and testbench

- Parametrised successor to the pipeline's static branch-prediction unit.
- Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Looked up combinationally in stage 0 using the current PC; supplies the predicted next PC to the PC source mux.
- Updated in stage 2 when the branch resolves; emits the mispredict/flush request and the recovery PC that drive the PR1/PR2 flush logic.

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/bp_sat_counter.sv | 30 +++
 rtl/dyn_branch_predictor.sv | 164 ++++++++++++++++
 tb/tb_dyn_branch_predictor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the dynamic branch predictor.
//                The optional statistics counters in dyn_branch_predictor are
//                enabled by defining the BRANCH_STATS_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Width of the resolved-branch and mispredict statistics counters
  localparam int STAT_W = 16;

  // Default geometry, used by the reference entry layout below
  localparam int DEF_ADDR_LEN = 12;
  localparam int DEF_IDX_BITS = 4;

  // Direction counter states for the default 2-bit counter
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_state_e;

  // One BTB entry at the default geometry
  typedef struct packed {
    logic                                 valid;
    logic [DEF_ADDR_LEN-DEF_IDX_BITS-1:0] tag;
    logic [DEF_ADDR_LEN-1:0]              target;
    ctr_state_e                           ctr;
  } btb_entry_t;

  // Weakly-not-taken value for a counter of arbitrary width (just below the MSB)
  function automatic int weak_nt_val(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Next-state function of a saturating direction counter.
//                Increments on taken, decrements on not taken, never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  input  logic                enable_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  // Saturating step toward the observed direction
  always_comb begin
    ctr_o = ctr_i;
    if (enable_i) begin
      if (taken_i) begin
        if (ctr_i != {CTR_BITS{1'b1}}) ctr_o = ctr_i + CTR_BITS'(1);
      end else begin
        if (ctr_i != {CTR_BITS{1'b0}}) ctr_o = ctr_i - CTR_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dyn_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : dyn_branch_predictor
//  Description : Direct-mapped BTB with per-entry saturating direction
//                counters. Combinational lookup in fetch, registered update at
//                branch resolution, combinational mispredict/recovery output.
//                Define BRANCH_STATS_EN to build the statistics counters;
//                otherwise both statistics outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dyn_branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_LEN = 12,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] lookup_pc,
  output logic                pred_taken,
  output logic [ADDR_LEN-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [ADDR_LEN-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_LEN-1:0] upd_target,
  input  logic                upd_pred_taken,
  input  logic [ADDR_LEN-1:0] upd_pred_target,
  output logic                mispredict,
  output logic [ADDR_LEN-1:0] recover_pc,
  input  logic                flush_tables,
  output logic [STAT_W-1:0]   stat_branches,
  output logic [STAT_W-1:0]   stat_mispredicts
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = ADDR_LEN - IDX_BITS;

  // The enum encoding is authoritative for the default 2-bit counter
  localparam logic [CTR_BITS-1:0] c_WEAK_NT = (CTR_BITS == 2) ? CTR_BITS'(WEAK_NT)
                                                              : CTR_BITS'(weak_nt_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] c_WEAK_T  = c_WEAK_NT + CTR_BITS'(1);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [ADDR_LEN-1:0] target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];
  entry_t btb_d [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  entry_t              lk_entry;
  logic                lk_hit;

  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]    up_tag;
  entry_t              up_entry;
  logic                up_hit;
  logic [CTR_BITS-1:0] up_ctr_nxt;

  assign lk_idx = lookup_pc[IDX_BITS-1:0];
  assign lk_tag = lookup_pc[ADDR_LEN-1:IDX_BITS];
  assign up_idx = upd_pc[IDX_BITS-1:0];
  assign up_tag = upd_pc[ADDR_LEN-1:IDX_BITS];

  // Fetch-stage lookup: reads the registered table, so no update bypass
  always_comb begin
    lk_entry    = btb_q[lk_idx];
    lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
    pred_taken  = lk_hit && lk_entry.ctr[CTR_BITS-1];
    pred_target = pred_taken ? lk_entry.target : lookup_pc + ADDR_LEN'(1);
  end

  // Resolution-stage mispredict detection and recovery address
  always_comb begin
    mispredict = 1'b0;
    recover_pc = '0;
    if (upd_valid) begin
      mispredict = (upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target));
      recover_pc = upd_taken ? upd_target : upd_pc + ADDR_LEN'(1);
    end
  end

  assign up_entry = btb_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_i    (up_entry.ctr),
    .taken_i  (upd_taken),
    .enable_i (up_hit),
    .ctr_o    (up_ctr_nxt)
  );

  // Table next state: flush clears valid bits and suppresses any update that cycle
  always_comb begin
    btb_d = btb_q;
    if (flush_tables) begin
      for (int i = 0; i < ENTRIES; i++) btb_d[i].valid = 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        btb_d[up_idx].ctr = up_ctr_nxt;
        if (upd_taken) btb_d[up_idx].target = upd_target;
      end else if (upd_taken) begin
        btb_d[up_idx].valid  = 1'b1;
        btb_d[up_idx].tag    = up_tag;
        btb_d[up_idx].target = upd_target;
        btb_d[up_idx].ctr    = c_WEAK_T;
      end
    end
  end

  // Table state register with asynchronous reset to empty, weakly-not-taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= c_WEAK_NT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= btb_d[i];
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  // Saturating statistics; flush_tables deliberately leaves them alone
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid && (stat_br_q != {STAT_W{1'b1}})) stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict && (stat_mp_q != {STAT_W{1'b1}})) stat_mp_d = stat_mp_q + STAT_W'(1);
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dyn_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dyn_branch_predictor
//  Description : Self-checking bench for dyn_branch_predictor: directed
//                scenarios plus randomized traffic against a behavioural
//                table model. Statistics expectations follow BRANCH_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dyn_branch_predictor;

  localparam int AL   = 12;
  localparam int N    = 16;
  localparam int PMOD = 1 << AL;
  localparam int SMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] lookup_pc;
  logic          pred_taken;
  logic [AL-1:0] pred_target;
  logic          upd_valid;
  logic [AL-1:0] upd_pc;
  logic          upd_taken;
  logic [AL-1:0] upd_target;
  logic          upd_pred_taken;
  logic [AL-1:0] upd_pred_target;
  logic          mispredict;
  logic [AL-1:0] recover_pc;
  logic          flush_tables;
  logic [15:0]   stat_branches;
  logic [15:0]   stat_mispredicts;

  always #5 clk = ~clk;

  dyn_branch_predictor #(
    .ADDR_LEN (AL),
    .ENTRIES  (N),
    .CTR_BITS (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .recover_pc       (recover_pc),
    .flush_tables     (flush_tables),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a table keyed by index, counter as a plain 0..3 integer
  int m_valid  [N];
  int m_tag    [N];
  int m_target [N];
  int m_ctr    [N];
  int m_br;
  int m_mp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  function automatic void m_lookup(input int pc, output int t, output int tg);
    int idx, hit;
    idx = pc % N;
    hit = (m_valid[idx] != 0) && (m_tag[idx] == pc / N);
    t   = (hit != 0 && m_ctr[idx] >= 2) ? 1 : 0;
    tg  = (t != 0) ? m_target[idx] : (pc + 1) % PMOD;
  endfunction

  function automatic int m_misp();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    if (upd_taken && upd_target != upd_pred_target) return 1;
    return 0;
  endfunction

  // Compare every output against the model (called away from the clock edge)
  task automatic settle();
    int t, tg, rc;
    @(negedge clk);
    m_lookup(int'(lookup_pc), t, tg);
    rc = !upd_valid ? 0 : (upd_taken ? int'(upd_target) : (int'(upd_pc) + 1) % PMOD);
    check_eq("pred_taken", pred_taken, t);
    check_eq("pred_target", pred_target, tg);
    check_eq("mispredict", mispredict, m_misp());
    check_eq("recover_pc", recover_pc, rc);
`ifdef BRANCH_STATS_EN
    check_eq("stat_branches", stat_branches, m_br);
    check_eq("stat_mispredicts", stat_mispredicts, m_mp);
`else
    check_eq("stat_branches", stat_branches, 0);
    check_eq("stat_mispredicts", stat_mispredicts, 0);
`endif
  endtask

  // Advance one clock and apply the resolution rules to the model
  task automatic tick();
    int idx, tag;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (upd_valid) m_br = (m_br < SMAX) ? m_br + 1 : SMAX;
      if (m_misp() != 0) m_mp = (m_mp < SMAX) ? m_mp + 1 : SMAX;
      idx = int'(upd_pc) % N;
      tag = int'(upd_pc) / N;
      if (flush_tables) begin
        for (int i = 0; i < N; i++) m_valid[i] = 0;
      end else if (upd_valid) begin
        if (m_valid[idx] != 0 && m_tag[idx] == tag) begin
          if (upd_taken) begin
            m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_target[idx] = int'(upd_target);
          end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[idx]  = 1;
          m_tag[idx]    = tag;
          m_target[idx] = int'(upd_target);
          m_ctr[idx]    = 2;
        end
      end
    end
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [AL-1:0] pc, input logic tk,
                           input logic [AL-1:0] tg, input logic ptk, input logic [AL-1:0] ptg);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = ptk; upd_pred_target = ptg;
  endtask

  initial begin
    int t, tg;
    rst = 1'b0;
    model_reset();
    lookup_pc = 12'h005;
    flush_tables = 1'b0;
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    @(posedge clk); #1;

    // Reset state, with a concurrent update held off by reset
    drive_upd(1'b1, 12'h005, 1'b1, 12'h040, 1'b0, 12'h006);
    settle();
    check_eq("rst_pred_taken", pred_taken, 1'b0);
    check_eq("rst_pred_target", pred_target, 12'h006);
    tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("rst_hold_taken", pred_taken, 1'b0);
    check_eq("rst_hold_target", pred_target, 12'h006);
    tick();
    rst = 1'b1;

    // Allocation on a taken miss
    drive_upd(1'b1, 12'h005, 1'b1, 12'h040, 1'b0, 12'h006);
    settle();
    check_eq("alloc_misp", mispredict, 1'b1);
    check_eq("alloc_recover", recover_pc, 12'h040);
    tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("alloc_pred_taken", pred_taken, 1'b1);
    check_eq("alloc_pred_target", pred_target, 12'h040);
    tick();

    // Counter walk down and saturating at zero
    drive_upd(1'b1, 12'h005, 1'b0, 12'h000, 1'b1, 12'h040);
    settle(); tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("nt1_pred_taken", pred_taken, 1'b0);
    tick();
    drive_upd(1'b1, 12'h005, 1'b0, 12'h000, 1'b0, 12'h006);
    settle(); tick();
    drive_upd(1'b1, 12'h005, 1'b0, 12'h000, 1'b0, 12'h006);
    settle(); tick();
    drive_upd(1'b1, 12'h005, 1'b1, 12'h040, 1'b0, 12'h006);
    settle(); tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("ctr01_pred_taken", pred_taken, 1'b0);
    tick();

    // Back to weakly taken, then aliasing index with a different tag
    drive_upd(1'b1, 12'h005, 1'b1, 12'h040, 1'b0, 12'h006);
    settle(); tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    lookup_pc = 12'h015;
    settle();
    check_eq("alias_pred_taken", pred_taken, 1'b0);
    check_eq("alias_pred_target", pred_target, 12'h016);
    tick();

    // Same-cycle lookup/update: old prediction now, new one next cycle
    lookup_pc = 12'h005;
    drive_upd(1'b1, 12'h005, 1'b0, 12'h000, 1'b1, 12'h040);
    settle();
    check_eq("same_old_taken", pred_taken, 1'b1);
    check_eq("same_old_target", pred_target, 12'h040);
    tick();
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("same_new_taken", pred_taken, 1'b0);
    tick();

    // Flush wins over a simultaneous allocation
    drive_upd(1'b1, 12'h005, 1'b1, 12'h040, 1'b0, 12'h006);
    settle(); tick();
    drive_upd(1'b1, 12'h123, 1'b1, 12'h0AA, 1'b0, 12'h124);
    flush_tables = 1'b1;
    settle(); tick();
    flush_tables = 1'b0;
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("flush_005_taken", pred_taken, 1'b0);
    tick();
    lookup_pc = 12'h123;
    settle();
    check_eq("flush_noalloc_taken", pred_taken, 1'b0);
    tick();

    // PC wrap on the fall-through target
    lookup_pc = 12'hFFF;
    settle();
    check_eq("wrap_target", pred_target, 12'h000);
    tick();

    // Randomized traffic over a few aliasing tags per index
    for (int c = 0; c < 800; c++) begin
      lookup_pc    = AL'($urandom_range(0, 47));
      flush_tables = ($urandom_range(0, 39) == 0);
      upd_valid    = ($urandom_range(0, 3) != 0);
      upd_pc       = AL'($urandom_range(0, 47));
      upd_taken    = $urandom_range(0, 1) != 0;
      upd_target   = AL'($urandom_range(0, 7) * 32);
      if ($urandom_range(0, 1) != 0) begin
        m_lookup(int'(upd_pc), t, tg);
        upd_pred_taken  = (t != 0);
        upd_pred_target = AL'(tg);
      end else begin
        upd_pred_taken  = $urandom_range(0, 1) != 0;
        upd_pred_target = AL'($urandom_range(0, 7) * 32);
      end
      if (c % 97 == 50) lookup_pc = 12'hFFF;
      settle(); tick();
    end
    flush_tables = 1'b0;

`ifdef BRANCH_STATS_EN
    // Long run of mispredicted branches drives both counters into saturation
    for (int c = 0; c < 70000; c++) begin
      drive_upd(1'b1, AL'(c % 64), 1'b1, 12'h100, 1'b0, 12'h000);
      tick();
    end
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle();
    check_eq("sat_branches", stat_branches, 16'hFFFF);
    check_eq("sat_mispredicts", stat_mispredicts, 16'hFFFF);
    tick();
`else
    drive_upd(1'b1, 12'h033, 1'b1, 12'h100, 1'b0, 12'h000);
    settle();
    check_eq("nostats_branches", stat_branches, 16'h0000);
    check_eq("nostats_mispredicts", stat_mispredicts, 16'h0000);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
